// File: rtl/mem_pkg.sv
// Shared types and constants for the load/store memory responder.
package mem_pkg;
  typedef enum logic [1:0] {MS_IDLE, MS_WAIT, MS_RESP} mem_state_t;

  localparam int MEM_ADDR_W = 14;
  localparam int MEM_DATA_W = 16;
  localparam logic [MEM_DATA_W-1:0] MEM_ERR_DATA = 16'h0000;
endpackage

// File: rtl/mem_responder_if.sv
// Processor <-> memory request bus; the data lines are shared and tri-stated.
interface mem_responder_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
);
  logic              processor_req;
  logic              load;
  logic              store;
  logic [ADDR_W-1:0] addr;
  wire  [DATA_W-1:0] datatofrommem;
  logic              processor_resp;
  logic              mem_done;
  logic [7:0]        datatoinst;
  logic              mem_err;

  modport slave (
    input  processor_req, load, store, addr,
    inout  datatofrommem,
    output processor_resp, mem_done, datatoinst, mem_err
  );

  modport master (
    output processor_req, load, store, addr,
    inout  datatofrommem,
    input  processor_resp, mem_done, datatoinst, mem_err
  );
endinterface

// File: rtl/mem_array.sv
// Word array: synchronous write, asynchronous read, contents survive reset.
module mem_array #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 16,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk)
    if (i_we) r_mem[i_addr] <= i_wdata;

  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: edge-triggered accept, programmable wait states,
// then a one-cycle response that commits a store or drives load data.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  mem_responder_if.slave   bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mem_state_t        r_state, w_next;
  logic [3:0]        r_cnt;
  logic              r_req_d, r_resp, r_load, r_store, r_err;
  logic [AW-1:0]     r_addr;
  logic [DATA_W-1:0] r_wdata, w_rdata, w_out;
  logic              w_accept, w_addr_bad, w_we, w_done, w_bus_oe;

  // Only a rising edge of req starts a transaction, so a held req is seen once.
  assign w_accept   = (r_state == MS_IDLE) && bus.processor_req && !r_req_d;
  assign w_addr_bad = 32'(bus.addr) >= 32'(DEPTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= MS_IDLE;
      r_cnt   <= '0;
      r_req_d <= 1'b0;
      r_resp  <= 1'b0;
      r_load  <= 1'b0;
      r_store <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_req_d <= bus.processor_req;
      r_resp  <= w_accept;
      r_cnt   <= (r_state == MS_WAIT) ? r_cnt + 4'd1 : 4'd0;
      if (w_accept) begin
        r_load  <= bus.load;
        r_store <= bus.store;
        r_err   <= (bus.load == bus.store) || w_addr_bad;
        r_addr  <= bus.addr[AW-1:0];
        r_wdata <= bus.datatofrommem;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      MS_IDLE: if (w_accept) w_next = (WAIT_CYCLES == 0) ? MS_RESP : MS_WAIT;
      MS_WAIT: if (r_cnt == 4'(WAIT_CYCLES - 1)) w_next = MS_RESP;
      MS_RESP: w_next = MS_IDLE;
      default: w_next = MS_IDLE;
    endcase
  end

  mem_array #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  // Outputs decode straight from state so reset clears them and the bus at once.
  assign w_done   = (r_state == MS_RESP);
  assign w_we     = w_done && r_store && !r_err;
  assign w_out    = r_err ? DATA_W'(MEM_ERR_DATA) : w_rdata;
  assign w_bus_oe = w_done && (r_load || r_err);

  assign bus.processor_resp = r_resp;
  assign bus.mem_done       = w_done;
  assign bus.mem_err        = w_done && r_err;
  assign bus.datatoinst     = w_bus_oe ? w_out[7:0] : 8'h00;
  assign bus.datatofrommem  = w_bus_oe ? w_out : {DATA_W{1'bz}};
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: WAIT_CYCLES=2 instance driven from a vector table, plus a
// WAIT_CYCLES=0 instance and hand sequences for held/ignored requests and reset.
module tb_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(14), .DATA_W(16)) ia ();
  mem_responder_if #(.ADDR_W(14), .DATA_W(16)) ib ();

  logic [15:0] drv_a = '0, drv_b = '0;
  logic        oe_a = 1'b0, oe_b = 1'b0;
  assign ia.datatofrommem = oe_a ? drv_a : 16'hzzzz;
  assign ib.datatofrommem = oe_b ? drv_b : 16'hzzzz;

  mem_responder #(.ADDR_W(14), .DATA_W(16), .DEPTH(1024), .WAIT_CYCLES(2)) u_a (
    .clk(clk), .reset(reset), .bus(ia));
  mem_responder #(.ADDR_W(14), .DATA_W(16), .DEPTH(1024), .WAIT_CYCLES(0)) u_b (
    .clk(clk), .reset(reset), .bus(ib));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic req, input logic ld, input logic st,
                       input logic [13:0] ad);
    if (sel) begin
      ib.processor_req = req; ib.load = ld; ib.store = st; ib.addr = ad;
    end else begin
      ia.processor_req = req; ia.load = ld; ia.store = st; ia.addr = ad;
    end
  endtask

  // One complete transaction; latencies are counted in cycles after the accept edge.
  task automatic op(input bit sel, input logic ld, input logic st, input logic [13:0] ad,
                    input logic [15:0] wd, output int resp_c, output int done_c,
                    output logic [15:0] rd, output logic [7:0] inst, output logic err);
    logic r, d;
    resp_c = -1; done_c = -1; rd = '0; inst = '0; err = 1'b0;
    @(negedge clk);
    drive(sel, 1'b1, ld, st, ad);
    if (sel) begin drv_b = wd; oe_b = 1'b1; end else begin drv_a = wd; oe_a = 1'b1; end
    @(posedge clk);
    #1 oe_a = 1'b0; oe_b = 1'b0;
    for (int c = 1; c <= 20 && done_c < 0; c++) begin
      @(negedge clk);
      r = sel ? ib.processor_resp : ia.processor_resp;
      d = sel ? ib.mem_done : ia.mem_done;
      if (r && resp_c < 0) resp_c = c;
      if (d) begin
        done_c = c;
        rd   = sel ? ib.datatofrommem : ia.datatofrommem;
        inst = sel ? ib.datatoinst : ia.datatoinst;
        err  = sel ? ib.mem_err : ia.mem_err;
      end
    end
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 1'b0, 14'd0);
    @(negedge clk);
  endtask

  typedef struct {
    logic        ld, st;
    logic [13:0] ad;
    logic [15:0] wd;
    logic        exp_err;
    bit          chk_data;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vt[14];

  initial begin
    int rc, dc, nr, nd;
    logic [15:0] rd;
    logic [7:0]  inst;
    logic        err;
    bit          seen;

    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);

    vt[0]  = '{1'b0, 1'b1, 14'd5,    16'hBEEF, 1'b0, 1'b0, 16'h0000};
    vt[1]  = '{1'b1, 1'b0, 14'd5,    16'h0000, 1'b0, 1'b1, 16'hBEEF};
    vt[2]  = '{1'b0, 1'b1, 14'd7,    16'h5555, 1'b0, 1'b0, 16'h0000};
    vt[3]  = '{1'b1, 1'b1, 14'd7,    16'h9999, 1'b1, 1'b1, 16'h0000};
    vt[4]  = '{1'b1, 1'b0, 14'd7,    16'h0000, 1'b0, 1'b1, 16'h5555};
    vt[5]  = '{1'b0, 1'b1, 14'd976,  16'h0F0F, 1'b0, 1'b0, 16'h0000};
    vt[6]  = '{1'b0, 1'b1, 14'd2000, 16'h1111, 1'b1, 1'b0, 16'h0000};
    vt[7]  = '{1'b1, 1'b0, 14'd976,  16'h0000, 1'b0, 1'b1, 16'h0F0F};
    vt[8]  = '{1'b1, 1'b0, 14'd2000, 16'h0000, 1'b1, 1'b1, 16'h0000};
    vt[9]  = '{1'b0, 1'b0, 14'd3,    16'h0000, 1'b1, 1'b1, 16'h0000};
    vt[10] = '{1'b0, 1'b1, 14'd1023, 16'hA5C3, 1'b0, 1'b0, 16'h0000};
    vt[11] = '{1'b1, 1'b0, 14'd1023, 16'h0000, 1'b0, 1'b1, 16'hA5C3};
    vt[12] = '{1'b0, 1'b1, 14'd9,    16'h0001, 1'b0, 1'b0, 16'h0000};
    vt[13] = '{1'b1, 1'b0, 14'd9,    16'h0000, 1'b0, 1'b1, 16'h0001};

    repeat (3) @(negedge clk);
    chk("rst_resp_a", {31'd0, ia.processor_resp}, 0);
    chk("rst_done_a", {31'd0, ia.mem_done}, 0);
    chk("rst_err_a",  {31'd0, ia.mem_err}, 0);
    chk("rst_inst_a", {24'd0, ia.datatoinst}, 0);
    chk("rst_oe_a",   {31'd0, u_a.w_bus_oe}, 0);
    chk("rst_oe_b",   {31'd0, u_b.w_bus_oe}, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      op(0, vt[i].ld, vt[i].st, vt[i].ad, vt[i].wd, rc, dc, rd, inst, err);
      chk($sformatf("v%0d_resp_lat", i), 32'(rc), 1);
      chk($sformatf("v%0d_done_lat", i), 32'(dc), 3);
      chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vt[i].exp_err});
      if (vt[i].chk_data) begin
        chk($sformatf("v%0d_data", i), {16'd0, rd}, {16'd0, vt[i].exp_data});
        chk($sformatf("v%0d_inst", i), {24'd0, inst}, {24'd0, vt[i].exp_data[7:0]});
      end
    end

    // Zero wait states: accept ack and completion coincide.
    op(1, 1'b0, 1'b1, 14'd0, 16'h1234, rc, dc, rd, inst, err);
    chk("zw_store_resp", 32'(rc), 1);
    chk("zw_store_done", 32'(dc), 1);
    op(1, 1'b1, 1'b0, 14'd0, 16'h0000, rc, dc, rd, inst, err);
    chk("zw_load_resp", 32'(rc), 1);
    chk("zw_load_done", 32'(dc), 1);
    chk("zw_load_data", {16'd0, rd}, 32'h1234);
    chk("zw_load_inst", {24'd0, inst}, 32'h34);
    chk("zw_load_err",  {31'd0, err}, 0);

    // Held request: one transaction for a 20-cycle level, then a second after a gap.
    nr = 0; nd = 0;
    @(negedge clk); drive(0, 1, 1, 0, 14'd5);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      nr += int'(ia.processor_resp); nd += int'(ia.mem_done);
    end
    chk("held_resp_cnt", 32'(nr), 1);
    chk("held_done_cnt", 32'(nd), 1);
    ia.processor_req = 1'b0;
    @(negedge clk); ia.processor_req = 1'b1;
    nd = 0; rd = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ia.mem_done) begin nd++; rd = ia.datatofrommem; end
    end
    chk("held_second_done", 32'(nd), 1);
    chk("held_second_data", {16'd0, rd}, 32'hBEEF);
    @(negedge clk); drive(0, 0, 0, 0, 0);
    @(negedge clk);

    // Extra req edges sampled in WAIT (t=1) and in RESP (t=2) must be ignored.
    for (int t = 1; t <= 2; t++) begin
      nr = 0; nd = 0;
      @(negedge clk); drive(0, 1, 1, 0, 14'd7);
      @(posedge clk);
      for (int c = 1; c <= 15; c++) begin
        @(negedge clk);
        nr += int'(ia.processor_resp); nd += int'(ia.mem_done);
        if (c == t) ia.processor_req = 1'b0;
        if (c == t + 1) ia.processor_req = 1'b1;
      end
      chk($sformatf("ign%0d_resp_cnt", t), 32'(nr), 1);
      chk($sformatf("ign%0d_done_cnt", t), 32'(nd), 1);
      drive(0, 0, 0, 0, 0);
      @(negedge clk);
    end

    // Reset during WAIT of a store: outputs clear immediately, no write lands.
    @(negedge clk); drive(0, 1, 0, 1, 14'd9); drv_a = 16'hAAAA; oe_a = 1'b1;
    @(posedge clk); #1 oe_a = 1'b0;
    @(negedge clk);
    chk("mrst_resp_before", {31'd0, ia.processor_resp}, 1);
    #2 reset = 1'b1;
    #1;
    chk("mrst_resp_async", {31'd0, ia.processor_resp}, 0);
    chk("mrst_done_async", {31'd0, ia.mem_done}, 0);
    chk("mrst_oe_async",   {31'd0, u_a.w_bus_oe}, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    op(0, 1'b1, 1'b0, 14'd9, 16'h0000, rc, dc, rd, inst, err);
    chk("mrst_addr9_data", {16'd0, rd}, 32'h0001);
    chk("mrst_addr9_err",  {31'd0, err}, 0);

    // Reset while a load is on the bus releases it without waiting for a clock.
    @(negedge clk); drive(0, 1, 1, 0, 14'd5);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = ia.mem_done;
    end
    chk("rresp_done_seen", {31'd0, seen}, 1);
    chk("rresp_oe_before", {31'd0, u_a.w_bus_oe}, 1);
    #2 reset = 1'b1;
    #1;
    chk("rresp_oe_async",   {31'd0, u_a.w_bus_oe}, 0);
    chk("rresp_done_async", {31'd0, ia.mem_done}, 0);
    chk("rresp_inst_async", {24'd0, ia.datatoinst}, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the processor's load/store request interface. It accepts one request at a time from the processor, stalls for a programmable number of wait states, then either commits a store into its internal word array or returns load data on the shared bidirectional data bus. It signals completion with a one-cycle `mem_done` pulse, with the low byte also copied to the instruction unit. It sits behind `processor_if` and is the target that processor-side drivers run against.

## Interface
- `ADDR_W`, 14: request address width.
- `DATA_W`, 16: data bus and word width.
- `DEPTH`, 1024: implemented words (power of two); valid addresses are 0..DEPTH-1.
- `WAIT_CYCLES`, 2: wait states between accept and completion (0..15).

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `processor_req`  in  1  request level; the initiator holds it until `mem_done`.
- `load`  in  1  read request qualifier, sampled at accept.
- `store`  in  1  write request qualifier, sampled at accept.
- `addr`  in  ADDR_W  word address, sampled at accept.
- `datatofrommem`  inout  DATA_W  store data in at accept; load data out during the response cycle; high-Z otherwise.
- `processor_resp`  out  1  one-cycle accept acknowledge.
- `mem_done`  out  1  one-cycle completion pulse.
- `datatoinst`  out  8  low byte of load data, valid with `mem_done`.
- `mem_err`  out  1  error flag, valid with `mem_done`.

## Operation
- **FSM states:**
  - IDLE → WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0) on accept.
  - WAIT → RESP when the wait counter reaches WAIT_CYCLES-1.
  - RESP → IDLE unconditionally.
- **Accept:** in IDLE on a rising edge of `processor_req` (current high, previous-cycle registered copy low). The responder latches `addr`, `load`, `store` and the bus data, and pulses `processor_resp` in the following cycle.
- **Held request:** a request held high after `mem_done` is not re-accepted. The initiator must drop `processor_req` for at least one cycle between requests.
- **Store:** the array is written with the latched data on the clock edge that ends RESP.
- **Load:**
  - During RESP, `datatofrommem` is driven with `mem[addr]` and `datatoinst` = data[7:0].
  - The bus is released (Z) in every other state.
- **Errors:** an error raises `mem_err` with `mem_done`, performs no write, and drives load data as 0. Error conditions:
  - `load` and `store` both high, or both low, at accept.
  - `addr` ≥ DEPTH.
- **Requests outside IDLE** (WAIT/RESP) are ignored.
- **Array contents** are not cleared by reset.

## Timing
- **Reset values:** `processor_resp`=0, `mem_done`=0, `datatoinst`=0, `mem_err`=0, bus Z, state IDLE, wait counter 0, request edge register 0.
- **Latency:** with accept sampled at edge N, `processor_resp` is high in cycle N+1 and `mem_done` is high in cycle N+1+WAIT_CYCLES.
- **WAIT_CYCLES=0:** `processor_resp` and `mem_done` are high in the same cycle.
- **Mid-operation reset:** the operation is aborted, no array write occurs, and the bus releases immediately (asynchronous).
- **Back-to-back requests:** minimum period is WAIT_CYCLES+3 cycles (accept, waits, RESP, one req-low cycle).
- **Bus turnaround:** the responder never drives the bus in the cycle of accept, so there is no contention with store data.

## Structure
- **Shared package** (`mem_pkg` or added to the existing ALU package):
  - `mem_state_t` enum {MS_IDLE, MS_WAIT, MS_RESP}.
  - `MEM_ADDR_W`=14 and `MEM_DATA_W`=16 constants.
  - `MEM_ERR_DATA`=16'h0000.
- **Sub-module `mem_array`:** DEPTH×DATA_W, synchronous write, asynchronous read. `mem_responder` holds the FSM, counter, edge detect and tri-state driver.

## Test plan
- **Store then load:** store 16'hBEEF to addr 5, then load addr 5 (WAIT_CYCLES=2).
  - `processor_resp` one cycle after each accept.
  - `mem_done` 3 cycles after accept.
  - Load returns 16'hBEEF with `datatoinst`=8'hEF and `mem_err`=0.
- **Zero wait states:** WAIT_CYCLES=0, load addr 0 after storing 16'h1234.
  - `processor_resp` and `mem_done` coincide one cycle after accept.
  - Data is 16'h1234.
- **Illegal requests:**
  - `load`=`store`=1 at addr 7 holding 16'h5555 → `mem_err`=1, returned data 0, addr 7 still 16'h5555 on a later load.
  - `addr`=14'd2000 store → `mem_err`=1, no write.
- **Held request:** `processor_req` held high for 20 cycles with one load → exactly one `processor_resp` and one `mem_done`. After req drops one cycle and rises again, a second transaction completes.
- **Mid-operation reset:** `reset` asserted during WAIT of a store of 16'hAAAA to addr 9 (previously 16'h0001).
  - Outputs go to 0 and the bus goes to Z asynchronously.
  - A later load of addr 9 returns 16'h0001.
- **Ignored requests:** a new req edge during WAIT and RESP is ignored; only the original transaction completes.
